pipe_issue: RTL and testbench

Operand issuer for the 3-stage arithmetic pipeline (F = (A+B + C−D) × D). Buffers operand sets from an upstream valid/ready source in a small FIFO and drives one set per clock onto the pipeline inputs. Tags each issued set with a sequence number. Tracks in-flight sets with a delay line so every pipeline result leaves with a valid strobe and its tag. Sits between the operand producer and the arithmetic pipeline, and owns both the pipeline's input end and its result end.

---
 rtl/pipe_issue_if.sv | 40 ++++
 rtl/pipe_issue.sv | 148 ++++++++++++++
 tb/tb_pipe_issue.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_if.sv
// Operand issuer bus: upstream valid/ready operand port, pipeline operand/result
// port and the tagged result strobe, grouped so they travel together.
interface pipe_issue_if #(
   parameter int unsigned N     = 10,
   parameter int unsigned DEPTH = 4
) ();

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_A;
   logic [N-1:0]  in_B;
   logic [N-1:0]  in_C;
   logic [N-1:0]  in_D;
   logic          issue_en;
   logic [N-1:0]  A;
   logic [N-1:0]  B;
   logic [N-1:0]  C;
   logic [N-1:0]  D;
   logic          issue;
   logic [N-1:0]  F;
   logic          res_valid;
   logic [N-1:0]  res_F;
   logic [3:0]    res_tag;
   logic [LW-1:0] level;

   // Producer / pipeline side
   modport master (
      output in_valid, in_A, in_B, in_C, in_D, issue_en, F,
      input  in_ready, A, B, C, D, issue, res_valid, res_F, res_tag, level
   );

   // Issuer side
   modport slave (
      input  in_valid, in_A, in_B, in_C, in_D, issue_en, F,
      output in_ready, A, B, C, D, issue, res_valid, res_F, res_tag, level
   );

endinterface

// File: rtl/pipe_issue.sv
// Operand issuer for the F = (A+B + C-D) x D pipeline. Buffers operand sets in a
// small FIFO, issues one tagged set per clock, and tracks in-flight sets with a
// delay line so each pipeline result is returned with a valid strobe and its tag.
module pipe_issue #(
   parameter int unsigned N     = 10,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 3
) (
   input logic         clk,
   input logic         reset,
   pipe_issue_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef logic [4*N-1:0] set_t;

   // FIFO state
   set_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          in_ready_q;
   logic          push;
   logic          pop;

   // Issue stage (stage 0 of the delay line is {issue_q, tag_q})
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [N-1:0]  c_q;
   logic [N-1:0]  d_q;
   logic          issue_q;
   logic [3:0]    tag_q;
   logic [3:0]    seq_q;

   // Delay line stages 1..LAT, stored at indices 0..LAT-1
   logic [LAT-1:0] dl_valid_q;
   logic [3:0]     dl_tag_q [LAT];

   // Result register
   logic          res_valid_q;
   logic [N-1:0]  res_f_q;
   logic [3:0]    res_tag_q;

   // Handshake decode and post-edge occupancy
   always_comb begin
      push    = bus.in_valid && in_ready_q;
      pop     = (level_q != '0) && bus.issue_en;
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   // FIFO storage; contents need no reset, pointers and level guard them
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= {bus.in_A, bus.in_B, bus.in_C, bus.in_D};
      end
   end

   // FIFO pointers, level and registered ready (from post-edge level)
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q    <= level_d;
         in_ready_q <= (level_d != LW'(DEPTH));
      end
   end

   // Issue: load head onto the pipeline inputs and tag it with the sequence number
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         issue_q <= 1'b0;
         tag_q   <= '0;
         seq_q   <= '0;
      end else if (pop) begin
         {a_q, b_q, c_q, d_q} <= mem_q[rd_ptr_q];
         issue_q <= 1'b1;
         tag_q   <= seq_q;
         seq_q   <= seq_q + 4'd1;
      end else begin
         issue_q <= 1'b0;
      end
   end

   // Delay line follows each issued set through the pipeline latency
   always_ff @(posedge clk) begin
      if (reset) begin
         dl_valid_q <= '0;
         for (int i = 0; i < int'(LAT); i++) begin
            dl_tag_q[i] <= '0;
         end
      end else begin
         dl_valid_q[0] <= issue_q;
         dl_tag_q[0]   <= tag_q;
         for (int i = 1; i < int'(LAT); i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_tag_q[i]   <= dl_tag_q[i-1];
         end
      end
   end

   // Capture F when the matching set reaches the end of the delay line
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid_q <= 1'b0;
         res_f_q     <= '0;
         res_tag_q   <= '0;
      end else begin
         res_valid_q <= dl_valid_q[LAT-1];
         if (dl_valid_q[LAT-1]) begin
            res_f_q   <= bus.F;
            res_tag_q <= dl_tag_q[LAT-1];
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.level     = level_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.C         = c_q;
   assign bus.D         = d_q;
   assign bus.issue     = issue_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_F     = res_f_q;
   assign bus.res_tag   = res_tag_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: models the arithmetic pipeline around the DUT, runs a
// directed vector table, directed corner sequences and random traffic, all
// checked every cycle against a queue-based reference model.
module tb_pipe_issue;

   localparam int unsigned N     = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_issue_if #(.N(N), .DEPTH(DEPTH)) bus ();

   pipe_issue #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Arithmetic pipeline environment: samples A..D each edge, F valid LAT cycles later
   logic [N-1:0] p1, p2, p3;
   always_ff @(posedge clk) begin
      p1 <= (bus.A + bus.B + bus.C - bus.D) * bus.D;
      p2 <= p1;
      p3 <= p2;
   end
   assign bus.F = p3;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] c;
      logic [N-1:0] d;
   } set_t;

   typedef struct {
      int           due;
      logic [N-1:0] f;
      int           tag;
   } res_t;

   typedef struct {
      bit           rst;
      bit           iv;
      bit           ie;
      set_t         s;
      bit           e_issue;
      bit           e_rv;
      int           e_rf;
      int           e_rtag;
      int           e_level;
      bit           e_ready;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   set_t         m_fifo[$];
   res_t         m_res[$];
   int           m_cyc = 0;
   int           m_seq;
   bit           m_ready;
   bit           m_issue;
   bit           m_rv;
   logic [N-1:0] m_a, m_b, m_c, m_d, m_rf;
   int           m_rtag;
   int           m_level;

   function automatic logic [N-1:0] ref_f(set_t s);
      int t;
      t = (int'(s.a) + int'(s.b) + int'(s.c) - int'(s.d)) * int'(s.d);
      return t[N-1:0];
   endfunction

   function automatic set_t mk_set(int a, int b, int c, int d);
      set_t s;
      s.a = a[N-1:0];
      s.b = b[N-1:0];
      s.c = c[N-1:0];
      s.d = d[N-1:0];
      return s;
   endfunction

   function automatic set_t rnd_set();
      return mk_set($urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
   endfunction

   function automatic vec_t mk(bit rst, bit iv, bit ie, int a, int b, int c, int d,
                               bit ei, bit erv, int erf, int etag, int elev, bit erdy);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ie = ie;
      v.s = mk_set(a, b, c, d);
      v.e_issue = ei; v.e_rv = erv; v.e_rf = erf; v.e_rtag = etag;
      v.e_level = elev; v.e_ready = erdy;
      return v;
   endfunction

   // Advance the model across one clock edge
   task automatic model_edge(bit rst, bit iv, bit ie, set_t s);
      bit   push;
      bit   pop;
      set_t h;
      res_t r;
      m_cyc++;
      if (rst) begin
         m_fifo.delete();
         m_res.delete();
         m_ready = 0; m_issue = 0; m_seq = 0; m_level = 0;
         m_a = '0; m_b = '0; m_c = '0; m_d = '0;
         m_rv = 0; m_rf = '0; m_rtag = 0;
      end else begin
         push = iv && m_ready;
         pop  = (m_fifo.size() != 0) && ie;
         if (pop) begin
            h = m_fifo.pop_front();
            m_issue = 1;
            m_a = h.a; m_b = h.b; m_c = h.c; m_d = h.d;
            r.due = m_cyc + int'(LAT) + 1;
            r.f   = ref_f(h);
            r.tag = m_seq;
            m_res.push_back(r);
            m_seq = (m_seq + 1) % 16;
         end else begin
            m_issue = 0;
         end
         if (push) m_fifo.push_back(s);
         m_level = m_fifo.size();
         m_ready = (m_fifo.size() != int'(DEPTH));
         m_rv = 0;
         if (m_res.size() != 0 && m_res[0].due == m_cyc) begin
            r = m_res.pop_front();
            m_rv = 1; m_rf = r.f; m_rtag = r.tag;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, m_cyc, act, exp);
      end
   endtask

   task automatic check_all();
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("level", 32'(bus.level), m_level);
      chk("issue", 32'(bus.issue), 32'(m_issue));
      chk("A", 32'(bus.A), 32'(m_a));
      chk("B", 32'(bus.B), 32'(m_b));
      chk("C", 32'(bus.C), 32'(m_c));
      chk("D", 32'(bus.D), 32'(m_d));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_F", 32'(bus.res_F), 32'(m_rf));
      chk("res_tag", 32'(bus.res_tag), m_rtag);
   endtask

   // Drive inputs at the falling edge, clock once, then check mid-cycle
   task automatic step(bit rst, bit iv, bit ie, set_t s);
      reset        = rst;
      bus.in_valid = iv;
      bus.issue_en = ie;
      bus.in_A     = s.a;
      bus.in_B     = s.b;
      bus.in_C     = s.c;
      bus.in_D     = s.d;
      @(posedge clk);
      model_edge(rst, iv, ie, s);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      step(1, 0, 0, mk_set(0, 0, 0, 0));
      step(0, 0, 0, mk_set(0, 0, 0, 0));
   endtask

   vec_t tbl[$];
   int   cnt_issue;
   int   cnt_rv;

   initial begin
      // Directed: reset, single set 3,4,10,2 -> F=30, tag 0, 4 cycles after issue
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 1, 3, 4, 10, 2, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 1, 30, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 30, 0, 0, 1));

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].iv, tbl[i].ie, tbl[i].s);
         chk("tbl_issue", 32'(bus.issue), 32'(tbl[i].e_issue));
         chk("tbl_res_valid", 32'(bus.res_valid), 32'(tbl[i].e_rv));
         chk("tbl_res_F", 32'(bus.res_F), tbl[i].e_rf);
         chk("tbl_res_tag", 32'(bus.res_tag), tbl[i].e_rtag);
         chk("tbl_level", 32'(bus.level), tbl[i].e_level);
         chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].e_ready));
      end

      // Stream 6 back-to-back: 6 consecutive issues and 6 results, tags 0..5
      do_reset();
      cnt_issue = 0; cnt_rv = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 1, rnd_set());
         cnt_issue += int'(bus.issue);
         cnt_rv    += int'(bus.res_valid);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, mk_set(0, 0, 0, 0));
         cnt_issue += int'(bus.issue);
         cnt_rv    += int'(bus.res_valid);
      end
      chk("stream_issue_cnt", cnt_issue, 6);
      chk("stream_res_cnt", cnt_rv, 6);

      // Fill: issue_en=0, 5 pushes, 5th refused; drain gives 4 results
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 1, 0, rnd_set());
      chk("fill_level", 32'(bus.level), 4);
      chk("fill_ready", 32'(bus.in_ready), 0);
      cnt_rv = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, mk_set(0, 0, 0, 0));
         cnt_rv += int'(bus.res_valid);
      end
      chk("fill_res_cnt", cnt_rv, 4);

      // Full FIFO with in_valid held and issue_en=1: simultaneous push/pop
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1, 0, rnd_set());
      for (int i = 0; i < 10; i++) step(0, 1, 1, rnd_set());
      for (int i = 0; i < 10; i++) step(0, 0, 1, mk_set(0, 0, 0, 0));

      // 18 sets: tags wrap 15 -> 0 -> 1
      do_reset();
      for (int i = 0; i < 18; i++) step(0, 1, 1, rnd_set());
      for (int i = 0; i < 8; i++) step(0, 0, 1, mk_set(0, 0, 0, 0));

      // Reset with 2 sets in flight and 2 in the FIFO
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1, 0, rnd_set());
      step(0, 0, 1, mk_set(0, 0, 0, 0));
      step(0, 0, 1, mk_set(0, 0, 0, 0));
      step(1, 0, 0, mk_set(0, 0, 0, 0));
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_issue", 32'(bus.issue), 0);
      cnt_rv = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, mk_set(0, 0, 0, 0));
         cnt_rv += int'(bus.res_valid);
      end
      chk("rst_no_res", cnt_rv, 0);
      step(0, 1, 1, mk_set(5, 6, 7, 3));
      for (int i = 0; i < 6; i++) step(0, 0, 1, mk_set(0, 0, 0, 0));
      chk("rst_first_tag", 32'(bus.res_tag), 0);
      chk("rst_first_F", 32'(bus.res_F), 45);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 63) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0, rnd_set());
      end
      for (int i = 0; i < 10; i++) step(0, 0, 1, mk_set(0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
